// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared encodings for the two-master bus arbiter: slave responses, tenure
// states and master identifiers.
package ahb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN1 = 2'b01,
    ST_OWN2 = 2'b10
  } state_e;

  typedef enum logic {
    MST_1 = 1'b0,
    MST_2 = 1'b1
  } master_e;

  function automatic state_e own_state(input master_e m);
    if (m == MST_2) return ST_OWN2;
    return ST_OWN1;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_arb_priority.sv
// Combinational winner select between the two eligible masters, either fixed
// priority (master 1 first) or round-robin against the most recent grant.
module ahb_bus_arbiter_arb_priority
  import ahb_bus_arbiter_pkg::*;
#(
  parameter logic RR_MODE = 1'b0
) (
  input  logic    elig_1_i,
  input  logic    elig_2_i,
  input  master_e last_grant_i,
  output logic    win_valid_o,
  output master_e winner_o
);

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    win_valid_o = elig_1_i | elig_2_i;
    winner_o    = MST_1;
    if (elig_1_i && elig_2_i) begin
      if (RR_MODE && (last_grant_i == MST_1)) begin
        winner_o = MST_2;
      end
    end else if (elig_2_i) begin
      winner_o = MST_2;
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master bus arbiter: tenure FSM, beat-limit counter, split parking and the
// registered address/data mux selects for the shared datapath.
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter logic RR_MODE  = 1'b0,
  parameter int   MAX_HOLD = 8,
  parameter int   CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busreq_1,
  input  logic       busreq_2,
  input  logic       ready,
  input  logic [1:0] response,
  input  logic [1:0] split_done,
  output logic       grant_1,
  output logic       grant_2,
  output logic       addr_sel,
  output logic       data_sel,
  output logic       data_valid,
  output logic [1:0] split_mask,
  output logic       error
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  master_e           last_q, last_d;
  logic [1:0]        mask_q, mask_d;
  logic              addr_sel_q, addr_sel_d;
  logic              data_sel_q, data_valid_q;
  logic              error_q, error_d;
  logic              grant_1_q, grant_2_q;

  logic    elig_1, elig_2;
  logic    split_1, split_2;
  logic    own_elig, other_elig;
  master_e other_mst;
  logic    win_valid;
  master_e winner;

  assign elig_1 = busreq_1 & ~mask_q[0];
  assign elig_2 = busreq_2 & ~mask_q[1];

  // A SPLIT removes the current owner from the same-cycle re-arbitration.
  assign split_1 = ready && (state_q == ST_OWN1) && (response == RESP_SPLIT);
  assign split_2 = ready && (state_q == ST_OWN2) && (response == RESP_SPLIT);

  assign own_elig   = (state_q == ST_OWN2) ? elig_2 : elig_1;
  assign other_elig = (state_q == ST_OWN2) ? elig_1 : elig_2;
  assign other_mst  = (state_q == ST_OWN2) ? MST_1  : MST_2;

  ahb_bus_arbiter_arb_priority #(
    .RR_MODE (RR_MODE)
  ) u_arb_priority (
    .elig_1_i     (elig_1 & ~split_1),
    .elig_2_i     (elig_2 & ~split_2),
    .last_grant_i (last_q),
    .win_valid_o  (win_valid),
    .winner_o     (winner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = own_state(winner);
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      ST_OWN1, ST_OWN2: begin
        if (ready) begin
          if (response == RESP_SPLIT) begin
            cnt_d = '0;
            if (win_valid) begin
              state_d = own_state(winner);
              last_d  = winner;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (response == RESP_RETRY) begin
            cnt_d = '0;
          end else begin
            // ERROR only raises the pulse; the beat is otherwise treated as OKAY.
            error_d = (response == RESP_ERROR);
            if (!own_elig) begin
              cnt_d   = '0;
              state_d = other_elig ? own_state(other_mst) : ST_IDLE;
              if (other_elig) last_d = other_mst;
            end else if ((cnt_q == LAST_BEAT) && other_elig) begin
              cnt_d   = '0;
              state_d = own_state(other_mst);
              last_d  = other_mst;
            end else if (cnt_q != LAST_BEAT) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A release and a new SPLIT for the same master in one cycle: the SPLIT wins.
  assign mask_d = (mask_q & ~split_done) | {split_2, split_1};

  always_comb begin
    addr_sel_d = addr_sel_q;
    if (state_d == ST_OWN1) addr_sel_d = 1'b0;
    if (state_d == ST_OWN2) addr_sel_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= MST_2;
      mask_q       <= '0;
      addr_sel_q   <= 1'b0;
      data_sel_q   <= 1'b0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
      grant_1_q    <= 1'b0;
      grant_2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      mask_q     <= mask_d;
      addr_sel_q <= addr_sel_d;
      error_q    <= error_d;
      grant_1_q  <= (state_d == ST_OWN1);
      grant_2_q  <= (state_d == ST_OWN2);
      if (ready) begin
        data_sel_q   <= addr_sel_q;
        data_valid_q <= (state_q != ST_IDLE);
      end
    end
  end

  assign grant_1    = grant_1_q;
  assign grant_2    = grant_2_q;
  assign addr_sel   = addr_sel_q;
  assign data_sel   = data_sel_q;
  assign data_valid = data_valid_q;
  assign split_mask = mask_q;
  assign error      = error_q;

endmodule
